// File: rtl/pad_cfg_sequencer.sv
// I/O ring pad-control sequencer: shadow bank of per-pad settings, applied on commit
// break-before-make (OE drop, guard, OE raise). Optional live readback via PAD_CFG_READBACK_EN.
module pad_cfg_sequencer #(
  parameter int unsigned NUM_INPUT_PADS = 12,
  parameter int unsigned NUM_BIDIR_PADS = 40,
  parameter int unsigned IDX_W          = 6,
  parameter int unsigned GUARD_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_sel,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [5:0]                cfg_data,
  input  logic                      commit,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      err_clr,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
`ifdef PAD_CFG_READBACK_EN
  ,
  input  logic                      rd_sel,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [5:0]                rd_data
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [IDX_W-1:0] INPUT_CNT = IDX_W'(NUM_INPUT_PADS);
  localparam logic [IDX_W-1:0] BIDIR_CNT = IDX_W'(NUM_BIDIR_PADS);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DROP  = 2'd1,
    GUARD = 2'd2,
    RAISE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  guard_cnt;

  logic [NUM_INPUT_PADS-1:0] sh_in_pu;
  logic [NUM_INPUT_PADS-1:0] sh_in_pd;
  logic [NUM_BIDIR_PADS-1:0] sh_oe;
  logic [NUM_BIDIR_PADS-1:0] sh_cs;
  logic [NUM_BIDIR_PADS-1:0] sh_sl;
  logic [NUM_BIDIR_PADS-1:0] sh_ie;
  logic [NUM_BIDIR_PADS-1:0] sh_pu;
  logic [NUM_BIDIR_PADS-1:0] sh_pd;

  logic wr_en_c;
  logic idx_ok_c;
  logic pull_conflict_c;
  logic pd_store_c;
  logic wr_err_c;
  logic cmd_err_c;

  // Write qualification and error detection
  always_comb begin
    wr_en_c         = cfg_valid && cfg_ready;
    idx_ok_c        = cfg_sel ? (cfg_idx < BIDIR_CNT) : (cfg_idx < INPUT_CNT);
    pull_conflict_c = cfg_data[4] && cfg_data[5];
    pd_store_c      = cfg_data[5] && !cfg_data[4];
    wr_err_c        = wr_en_c && (!idx_ok_c || pull_conflict_c);
    cmd_err_c       = commit && (state != IDLE);
  end

  // Shadow bank; writes only land in IDLE because cfg_ready gates them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_in_pu <= '0;
      sh_in_pd <= '0;
      sh_oe    <= '0;
      sh_cs    <= '0;
      sh_sl    <= '0;
      sh_ie    <= '1;
      sh_pu    <= '0;
      sh_pd    <= '0;
    end else if (wr_en_c && idx_ok_c) begin
      if (cfg_sel) begin
        for (int i = 0; i < int'(NUM_BIDIR_PADS); i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            sh_oe[i] <= cfg_data[0];
            sh_cs[i] <= cfg_data[1];
            sh_sl[i] <= cfg_data[2];
            sh_ie[i] <= cfg_data[3];
            sh_pu[i] <= cfg_data[4];
            sh_pd[i] <= pd_store_c;
          end
        end
      end else begin
        for (int i = 0; i < int'(NUM_INPUT_PADS); i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            sh_in_pu[i] <= cfg_data[4];
            sh_in_pd[i] <= pd_store_c;
          end
        end
      end
    end
  end

  // Sticky error: a new error in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= wr_err_c || cmd_err_c || (err && !err_clr);
    end
  end

  // Commit sequencer and live pad registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guard_cnt <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      input_pu  <= '0;
      input_pd  <= '0;
      bidir_oe  <= '0;
      bidir_cs  <= '0;
      bidir_sl  <= '0;
      bidir_ie  <= '1;
      bidir_pu  <= '0;
      bidir_pd  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (commit) begin
            state     <= DROP;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        DROP: begin
          // Only falling OE edges here; rising ones wait until the guard expires
          bidir_oe  <= bidir_oe & sh_oe;
          bidir_cs  <= sh_cs;
          bidir_sl  <= sh_sl;
          bidir_ie  <= sh_ie;
          bidir_pu  <= sh_pu;
          bidir_pd  <= sh_pd;
          input_pu  <= sh_in_pu;
          input_pd  <= sh_in_pd;
          guard_cnt <= GUARD_LOAD;
          state     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state <= RAISE;
          end else begin
            guard_cnt <= guard_cnt - CNT_W'(1);
          end
        end
        RAISE: begin
          bidir_oe  <= sh_oe;
          done      <= 1'b1;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PAD_CFG_READBACK_EN
  logic [5:0] rd_next_c;

  // Live-state mux; input pads expose only their pulls
  always_comb begin
    rd_next_c = '0;
    if (rd_sel) begin
      for (int i = 0; i < int'(NUM_BIDIR_PADS); i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rd_next_c = {bidir_pd[i], bidir_pu[i], bidir_ie[i],
                       bidir_sl[i], bidir_cs[i], bidir_oe[i]};
        end
      end
    end else begin
      for (int i = 0; i < int'(NUM_INPUT_PADS); i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rd_next_c = {input_pd[i], input_pu[i], 4'b0000};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next_c;
    end
  end
`endif

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: a shadow-bank model predicts live pad state,
// expected snapshots are queued at commit and checked when done pulses.
module tb_pad_cfg_sequencer;

  localparam int unsigned NI = 12;
  localparam int unsigned NB = 40;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_sel;
  logic [5:0]    cfg_idx;
  logic [5:0]    cfg_data;
  logic          commit;
  logic          busy;
  logic          done;
  logic          err;
  logic          err_clr;
  logic [NI-1:0] input_pu;
  logic [NI-1:0] input_pd;
  logic [NB-1:0] bidir_oe;
  logic [NB-1:0] bidir_cs;
  logic [NB-1:0] bidir_sl;
  logic [NB-1:0] bidir_ie;
  logic [NB-1:0] bidir_pu;
  logic [NB-1:0] bidir_pd;

  pad_cfg_sequencer #(
    .NUM_INPUT_PADS(NI),
    .NUM_BIDIR_PADS(NB),
    .IDX_W(6),
    .GUARD_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .commit(commit),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr),
    .input_pu(input_pu), .input_pd(input_pd),
    .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] oe, cs, sl, ie, pu, pd;
    logic [NI-1:0] ipu, ipd;
  } snap_t;

  snap_t sb_q[$];
  snap_t m;          // model of the shadow bank
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.oe = '0; m.cs = '0; m.sl = '0; m.ie = '1; m.pu = '0; m.pd = '0;
    m.ipu = '0; m.ipd = '0;
  endtask

  // Apply a write to the model; returns whether it should raise err
  function automatic logic model_write(input logic sel, input logic [5:0] idx, input logic [5:0] d);
    int i;
    logic pdv;
    i   = int'(idx);
    pdv = d[5] & ~d[4];
    if (sel) begin
      if (i >= int'(NB)) return 1'b1;
      m.oe[i] = d[0]; m.cs[i] = d[1]; m.sl[i] = d[2];
      m.ie[i] = d[3]; m.pu[i] = d[4]; m.pd[i] = pdv;
    end else begin
      if (i >= int'(NI)) return 1'b1;
      m.ipu[i] = d[4]; m.ipd[i] = pdv;
    end
    return d[4] & d[5];
  endfunction

  // Drive one shadow write; called at a negedge, returns at a negedge
  task automatic wr(input logic sel, input logic [5:0] idx, input logic [5:0] d, output logic e);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_data = d;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $error("FAIL wr_timeout observed=cfg_ready_low expected=ready_within_50");
    end
    @(posedge clk);
    e = model_write(sel, idx, d);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_commit();
    commit = 1'b1;
    sb_q.push_back(m);
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    snap_t e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    if (sb_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_oe"}, 64'(bidir_oe), 64'(e.oe));
      chk({tag, "_cs"}, 64'(bidir_cs), 64'(e.cs));
      chk({tag, "_sl"}, 64'(bidir_sl), 64'(e.sl));
      chk({tag, "_ie"}, 64'(bidir_ie), 64'(e.ie));
      chk({tag, "_pu"}, 64'(bidir_pu), 64'(e.pu));
      chk({tag, "_pd"}, 64'(bidir_pd), 64'(e.pd));
      chk({tag, "_ipu"}, 64'(input_pu), 64'(e.ipu));
      chk({tag, "_ipd"}, 64'(input_pd), 64'(e.ipd));
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({tag, "_done_one"}, 64'(done), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"}, 64'(bidir_oe), 64'(0));
    chk({tag, "_ie"}, 64'(bidir_ie), {24'd0, {NB{1'b1}}});
    chk({tag, "_pulls"}, 64'(bidir_pu | bidir_pd | bidir_cs | bidir_sl), 64'(0));
    chk({tag, "_ipulls"}, 64'(input_pu | input_pd), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_ready"}, 64'(cfg_ready), 64'(1));
  endtask

  initial begin
    logic e;
    int dcount;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_data = '0;
    commit = 1'b0; err_clr = 1'b0;
    model_reset();
    #23;
    chk_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_rel");

    // Baseline: pad 3 driving, then a plain commit
    wr(1'b1, 6'd3, 6'b001001, e);
    chk("wr3_err", 64'(err), 64'(e));
    start_commit();
    wait_done("c1");

    // Break-before-make: pad 3 OE off, pad 5 OE on
    wr(1'b1, 6'd3, 6'b001000, e);
    wr(1'b1, 6'd5, 6'b001011, e);
    commit = 1'b1;
    sb_q.push_back(m);
    @(negedge clk);                       // after E0
    commit = 1'b0;
    chk("bbm_e0_oe3", 64'(bidir_oe[3]), 64'(1));
    @(negedge clk);                       // after E1
    chk("bbm_e1_oe3", 64'(bidir_oe[3]), 64'(0));
    chk("bbm_e1_cs5", 64'(bidir_cs[5]), 64'(1));
    chk("bbm_e1_oe5", 64'(bidir_oe[5]), 64'(0));
    chk("bbm_e1_busy", 64'(busy), 64'(1));
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("bbm_e%0d_oe5", k), 64'(bidir_oe[5]), 64'(0));
      chk($sformatf("bbm_e%0d_busy", k), 64'(busy), 64'(1));
      chk($sformatf("bbm_e%0d_done", k), 64'(done), 64'(0));
    end
    @(negedge clk);                       // after E6
    chk("bbm_e6_oe5", 64'(bidir_oe[5]), 64'(1));
    wait_done("bbm");

    // Pull conflict on input pad 2
    wr(1'b0, 6'd2, 6'b110000, e);
    chk("conf_err", 64'(err), 64'(1));
    start_commit();
    wait_done("conf");
    chk("conf_ipu2", 64'(input_pu[2]), 64'(1));
    chk("conf_ipd2", 64'(input_pd[2]), 64'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("conf_clr", 64'(err), 64'(0));

    // err_clr colliding with a fresh error keeps err set
    err_clr = 1'b1;
    wr(1'b0, 6'd7, 6'b110000, e);
    err_clr = 1'b0;
    chk("clr_vs_new", 64'(err), 64'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Out-of-range bidir index: nothing changes
    wr(1'b1, 6'd45, 6'b011111, e);
    chk("range_err", 64'(err), 64'(1));
    start_commit();
    wait_done("range");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Same-cycle write and commit in IDLE: write is included
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_idx = 6'd39; cfg_data = 6'b011110;
    commit = 1'b1;
    e = model_write(1'b1, 6'd39, 6'b011110);
    sb_q.push_back(m);
    @(negedge clk);
    cfg_valid = 1'b0; commit = 1'b0;
    wait_done("same");

    // Commit during GUARD is ignored and flagged
    wr(1'b1, 6'd10, 6'b001101, e);
    start_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("ovl_err", 64'(err), 64'(1));
    wait_done("ovl");
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("ovl_extra_done", 64'(dcount), 64'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Write while busy stalls until IDLE
    start_commit();
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_idx = 6'd20; cfg_data = 6'b101011;
    @(negedge clk);
    chk("stall_ready", 64'(cfg_ready), 64'(0));
    wait_done("stall");
    cfg_valid = 1'b0;
    e = model_write(1'b1, 6'd20, 6'b101011);
    chk("stall_ready_back", 64'(cfg_ready), 64'(1));
    start_commit();
    wait_done("stall2");

    // Reset in the middle of GUARD
    wr(1'b1, 6'd0, 6'b000001, e);
    start_commit();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    void'(sb_q.pop_front());
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_commit();
    wait_done("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
